idft_output_capture: RTL and testbench
======================================

# idft_output_capture

Downstream capture stage for the IDFT core wrapper. It watches the core's `next_out` pulse, records the 32 output beats (`Y0`..`Y3`) of one 64-point inverse transform into an on-chip frame buffer, and holds the frame for the host-side register interface to read by beat index. A sticky overflow flag reports frames that were lost because the host had not yet released the previous one.

## Interface
Parameters:
- `BEATS`, 32: output beats per transform frame (2 complex samples per beat).
- `DATA_W`, 16: width of each Y lane.

Ports:
- Clock and reset: one clock, `clk`; `rst` is synchronous and active-high.
- `clk`  in  1  core clock, shared with the IDFT core.
- `rst`  in  1  synchronous active-high reset.
- `next_out`  in  1  single-cycle start-of-frame pulse from the IDFT core.
- `Y0`, `Y1`, `Y2`, `Y3`  in  DATA_W each  output lanes from the IDFT core: re0, im0, re1, im1.
- `rd_addr`  in  $clog2(BEATS)  beat index to read.
- `rd_en`  in  1  read strobe.
- `rd_data`  out  4*DATA_W  registered read word, `{Y3,Y2,Y1,Y0}`.
- `frame_valid`  out  1  a complete frame is held in the buffer.
- `frame_ack`  in  1  host releases the held frame.
- `overflow`  out  1  sticky flag: at least one frame was dropped.
- `overflow_clr`  in  1  clears `overflow`.
- `busy`  out  1  capture in progress.

## Operation
FSM states: `IDLE` (armed), `CAPTURE`, `FULL`.
- IDLE: when `next_out`=1, reset the beat counter to 0 and go to CAPTURE.
- CAPTURE: on every cycle, write `{Y3,Y2,Y1,Y0}` to `buf[cnt]` and increment `cnt`. After the write at `cnt==BEATS-1`, go to FULL.
- FULL: `frame_valid`=1. When `frame_ack`=1, go to IDLE.
- `next_out` while in FULL without `frame_ack`: the frame is dropped, `overflow` is set, and the state stays FULL.
- `next_out` and `frame_ack` in the same cycle while in FULL: the frame is accepted and the state goes directly to CAPTURE. The buffer is overwritten.
- `next_out` during CAPTURE: this is a protocol violation. It is ignored for capture, the current frame continues, and `overflow` is set.
- `frame_ack` outside FULL: no effect.
- `overflow_clr` and a new overflow event in the same cycle: the set wins.
- Reads:
  - `rd_data` updates only on `rd_en`. It holds its value otherwise.
  - Reads are legal in any state. During CAPTURE they return whatever word is currently at that address.
  - A read and a write to the same address in the same cycle returns the old data.
- Counter: `cnt` is $clog2(BEATS) bits wide and wraps only through the state change, never implicitly.

## Timing
- Reset values: state IDLE, `cnt`=0, `frame_valid`=0, `busy`=0, `overflow`=0, `rd_data`=0. Buffer contents are not cleared.
- `next_out` asserted at cycle t: the beats at t+1 .. t+BEATS are captured. `busy`=1 from t+1 through t+BEATS.
- `frame_valid` rises at t+BEATS+1.
- Read latency: `rd_en` at cycle r gives `rd_data` valid at r+1.
- `frame_ack` at cycle a: `frame_valid`=0 at a+1.
- `overflow` rises one cycle after the offending `next_out`.
- `rst` mid-capture: the state returns to IDLE on the next edge. A `next_out` pulse coincident with `rst` is ignored.

## Configuration
- `IDFT_CAPTURE_DROP_CNT_EN`
  - Defined: adds output `drop_count` (16 bits, reset 0). It increments on each dropped or overlapped frame, saturates at 0xFFFF, and is cleared by `overflow_clr` unless an increment occurs in the same cycle. In that case the increment wins and the value becomes 1.
  - Undefined: the port and counter are absent. `overflow` behaviour is unchanged.

## Structure
- The shared DSP package `dsp_pkg` holds:
  - `IDFT_CAPTURE_BEATS` (32) and `IDFT_CAPTURE_LANE_W` (16).
  - The state enum `idft_capture_state_t` (`IDLE`, `CAPTURE`, `FULL`).
- The sub-module `idft_capture_ram` is a simple dual-port BEATS x 4*DATA_W RAM with a synchronous write port, a registered read port and read-enable, and read-old-on-collision behaviour.
- The FSM, counter and flags stay in the top module.

## Test plan
- Single frame: `next_out` pulse, then lanes driven with beat k = `{16'h3000+k, 16'h2000+k, 16'h1000+k, k}`. Expect `frame_valid` at t+33. Reading addr 5 returns `64'h3005_2005_1005_0005`, and addr 31 returns `64'h301F_201F_101F_001F`.
- Drop: a second `next_out` while FULL with no ack. Expect `overflow`=1 and buffer addr 0 unchanged. With the macro defined, `drop_count`=1.
- Ack and next together: `frame_ack`=1 and `next_out`=1 in the same cycle while FULL. Expect no overflow, `busy`=1 the next cycle, and new data at addr 0 after the capture.
- Overlap: `next_out` at beat 10 of CAPTURE. Expect `overflow`=1 and `frame_valid` still at the original t+33.
- Reset mid-capture: `rst` at beat 12. Expect `busy`=0, `frame_valid`=0 and `overflow`=0 the next cycle. A following `next_out` captures normally.
- Saturation (macro defined): force 65,537 drops. Expect `drop_count`=0xFFFF. Then `overflow_clr` gives `drop_count`=0 and `overflow`=0.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP definitions: IDFT capture frame geometry and capture FSM states.
package dsp_pkg;

  // Output beats per 64-point inverse transform (2 complex samples per beat).
  localparam int IDFT_CAPTURE_BEATS  = 32;
  // Width of one Y lane from the IDFT core.
  localparam int IDFT_CAPTURE_LANE_W = 16;

  // IDLE: armed, CAPTURE: recording beats, FULL: frame held for the host.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } idft_capture_state_t;

endpackage

// File: rtl/idft_capture_ram.sv
// Simple dual-port frame buffer: synchronous write port, registered read port
// with read enable. A read and a write to the same address in one cycle
// return the previously stored word. The read register is cleared by reset;
// the memory contents are not.
module idft_capture_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port: store the incoming beat.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: the non-blocking write above lands after this sample,
  // so a same-address collision returns the old word.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/idft_output_capture.sv
// IDFT output capture: records one 32-beat inverse-transform frame on the
// core's next_out pulse and holds it for host reads until frame_ack.
// Optional feature macro: IDFT_CAPTURE_DROP_CNT_EN adds a saturating 16-bit
// drop_count output counting dropped or overlapped frames.
module idft_output_capture
  import dsp_pkg::*;
#(
  parameter int BEATS  = IDFT_CAPTURE_BEATS,
  parameter int DATA_W = IDFT_CAPTURE_LANE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     next_out,
  input  logic [DATA_W-1:0]        Y0,
  input  logic [DATA_W-1:0]        Y1,
  input  logic [DATA_W-1:0]        Y2,
  input  logic [DATA_W-1:0]        Y3,
  input  logic [$clog2(BEATS)-1:0] rd_addr,
  input  logic                     rd_en,
  output logic [4*DATA_W-1:0]      rd_data,
  output logic                     frame_valid,
  input  logic                     frame_ack,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic                     busy
`ifdef IDFT_CAPTURE_DROP_CNT_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int AW = $clog2(BEATS);
  localparam logic [AW-1:0] LAST_BEAT = AW'(BEATS - 1);

  idft_capture_state_t r_state;
  idft_capture_state_t w_state_next;
  logic [AW-1:0]       r_cnt;
  logic                r_overflow;
  logic                w_start;
  logic                w_drop_evt;
  logic                w_wr_en;
  logic [4*DATA_W-1:0] w_wr_data;

  // State register; reset wins over any coincident next_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus start / drop / write strobes.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_drop_evt   = 1'b0;
    w_wr_en      = 1'b0;
    case (r_state)
      IDLE: begin
        if (next_out) begin
          w_start      = 1'b1;
          w_state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        // A reset cycle does not commit a beat.
        w_wr_en = !rst;
        // A new start while capturing is a protocol violation: flag it,
        // keep recording the current frame.
        w_drop_evt = next_out;
        if (r_cnt == LAST_BEAT) begin
          w_state_next = FULL;
        end
      end
      FULL: begin
        if (frame_ack) begin
          if (next_out) begin
            // Host releases and the core starts in the same cycle:
            // accept the new frame, overwriting the buffer.
            w_start      = 1'b1;
            w_state_next = CAPTURE;
          end else begin
            w_state_next = IDLE;
          end
        end else if (next_out) begin
          w_drop_evt = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Beat counter: restarts on frame start, advances during capture and
  // holds at the last beat; it returns to 0 only through a new start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (r_state == CAPTURE && r_cnt != LAST_BEAT) begin
      r_cnt <= r_cnt + AW'(1);
    end
  end

  // Sticky overflow flag; a new drop event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop_evt) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef IDFT_CAPTURE_DROP_CNT_EN
  logic [15:0] r_drop_count;

  // Saturating drop counter; an increment coinciding with a clear
  // restarts the count at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_count <= '0;
    end else if (w_drop_evt) begin
      if (overflow_clr) begin
        r_drop_count <= 16'd1;
      end else if (r_drop_count != 16'hFFFF) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end else if (overflow_clr) begin
      r_drop_count <= '0;
    end
  end

  assign drop_count = r_drop_count;
`endif

  assign w_wr_data   = {Y3, Y2, Y1, Y0};
  assign busy        = (r_state == CAPTURE);
  assign frame_valid = (r_state == FULL);
  assign overflow    = r_overflow;

  idft_capture_ram #(
    .DEPTH (BEATS),
    .WIDTH (4*DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_rst   (rst),
    .i_we    (w_wr_en),
    .i_waddr (r_cnt),
    .i_wdata (w_wr_data),
    .i_re    (rd_en),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

endmodule

// File: tb/tb_idft_output_capture.sv
// Directed bench for idft_output_capture with a read-data scoreboard.
module tb_idft_output_capture;

  localparam int BEATS = 32;
  localparam int DW    = 16;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            next_out;
  logic [DW-1:0]   Y0, Y1, Y2, Y3;
  logic [AW-1:0]   rd_addr;
  logic            rd_en;
  logic [4*DW-1:0] rd_data;
  logic            frame_valid;
  logic            frame_ack;
  logic            overflow;
  logic            overflow_clr;
  logic            busy;
`ifdef IDFT_CAPTURE_DROP_CNT_EN
  logic [15:0]     drop_count;
  logic [15:0]     exp_dc;
`endif

  int checks   = 0;
  int failures = 0;

  logic [63:0] mdl [BEATS];
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  idft_output_capture dut (
    .clk          (clk),
    .rst          (rst),
    .next_out     (next_out),
    .Y0           (Y0),
    .Y1           (Y1),
    .Y2           (Y2),
    .Y3           (Y3),
    .rd_addr      (rd_addr),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .frame_valid  (frame_valid),
    .frame_ack    (frame_ack),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .busy         (busy)
`ifdef IDFT_CAPTURE_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_word(input logic [15:0] seed, input int k);
    logic [15:0] b;
    b = seed + 16'(k);
    return {16'h3000 + b, 16'h2000 + b, 16'h1000 + b, b};
  endfunction

  task automatic drive_lanes(input logic [63:0] w);
    {Y3, Y2, Y1, Y0} = w;
  endtask

  // Read one address; expected word is taken from the bench model.
  task automatic do_read(input int a, input string tag);
    logic [63:0] e;
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    sb.push_back(mdl[a]);
    step();
    rd_en = 1'b0;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check(tag, rd_data, e);
      $display("read addr=%0d data=%h expected=%h", a, rd_data, e);
    end
  endtask

  // Drives one start pulse and 32 beats. Optional: overlapping next_out at
  // ovl_beat, same-address read at rd_beat, reset (with next_out) at rst_beat.
  task automatic run_frame(input logic [15:0] seed, input bit with_ack,
                           input int ovl_beat, input int rd_beat, input int rst_beat);
    logic [63:0] w;
    logic [63:0] e;
    next_out  = 1'b1;
    frame_ack = with_ack;
    step();
    next_out  = 1'b0;
    frame_ack = 1'b0;
    check("busy_start", {63'd0, busy}, 64'd1);
    for (int k = 0; k < BEATS; k++) begin
      w = beat_word(seed, k);
      drive_lanes(w);
      if (k == ovl_beat) next_out = 1'b1;
      if (k == rst_beat) begin
        rst      = 1'b1;
        next_out = 1'b1;
      end
      if (k == rd_beat) begin
        rd_en   = 1'b1;
        rd_addr = AW'(k);
        sb.push_back(mdl[k]);
      end
      if (k == BEATS - 1) begin
        check("fv_before_end", {63'd0, frame_valid}, 64'd0);
        check("busy_last_beat", {63'd0, busy}, 64'd1);
      end
      step();
      next_out = 1'b0;
      rd_en    = 1'b0;
      if (k == rd_beat) begin
        e = sb.pop_front();
        check("rd_collision_old", rd_data, e);
      end
      if (k == ovl_beat) begin
        check("ovl_overflow", {63'd0, overflow}, 64'd1);
        check("ovl_busy", {63'd0, busy}, 64'd1);
      end
      if (k == rst_beat) begin
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_fv", {63'd0, frame_valid}, 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);
        rst = 1'b0;
        step();
        check("rst_next_ignored", {63'd0, busy}, 64'd0);
        $display("frame seed=%h reset at beat %0d", seed, k);
        return;
      end
      mdl[k] = w;
    end
    check("fv_end", {63'd0, frame_valid}, 64'd1);
    check("busy_end", {63'd0, busy}, 64'd0);
    $display("frame seed=%h captured frame_valid=%0b", seed, frame_valid);
  endtask

  initial begin
    rst = 1'b1; next_out = 1'b0; rd_en = 1'b0; rd_addr = '0;
    frame_ack = 1'b0; overflow_clr = 1'b0;
    drive_lanes(64'd0);
    for (int i = 0; i < BEATS; i++) mdl[i] = 64'd0;
`ifdef IDFT_CAPTURE_DROP_CNT_EN
    exp_dc = 16'd0;
`endif
    repeat (3) step();
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_fv", {63'd0, frame_valid}, 64'd0);
    check("reset_ovf", {63'd0, overflow}, 64'd0);
    check("reset_rd_data", rd_data, 64'd0);
`ifdef IDFT_CAPTURE_DROP_CNT_EN
    check("reset_dc", {48'd0, drop_count}, 64'd0);
`endif
    rst = 1'b0;
    step();

    // Single frame.
    run_frame(16'h0000, 1'b0, -1, -1, -1);
    do_read(5, "rd5");
    check("rd5_const", rd_data, 64'h3005_2005_1005_0005);
    step();
    check("rd_hold", rd_data, 64'h3005_2005_1005_0005);
    do_read(31, "rd31");
    check("rd31_const", rd_data, 64'h301F_201F_101F_001F);

    // Drop while FULL, overflow_clr in the same cycle loses to the set.
    drive_lanes({$urandom, $urandom});
    next_out = 1'b1;
    overflow_clr = 1'b1;
    step();
    next_out = 1'b0;
    overflow_clr = 1'b0;
    drive_lanes({$urandom, $urandom});
    check("drop_ovf", {63'd0, overflow}, 64'd1);
    check("drop_fv", {63'd0, frame_valid}, 64'd1);
`ifdef IDFT_CAPTURE_DROP_CNT_EN
    exp_dc = 16'd1;
    check("drop_dc", {48'd0, drop_count}, {48'd0, exp_dc});
`endif
    repeat (4) step();
    do_read(0, "drop_rd0");

    // Clear overflow.
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    check("clr_ovf", {63'd0, overflow}, 64'd0);
`ifdef IDFT_CAPTURE_DROP_CNT_EN
    exp_dc = 16'd0;
    check("clr_dc", {48'd0, drop_count}, {48'd0, exp_dc});
`endif

    // Ack and next together: accepted, no overflow.
    run_frame(16'h0040, 1'b1, -1, -1, -1);
    check("acknext_ovf", {63'd0, overflow}, 64'd0);
    do_read(0, "acknext_rd0");
    check("acknext_rd0_const", rd_data, 64'h3040_2040_1040_0040);

    // Release, then ack outside FULL has no effect.
    frame_ack = 1'b1;
    step();
    check("ack_fv", {63'd0, frame_valid}, 64'd0);
    step();
    frame_ack = 1'b0;
    check("idle_ack_busy", {63'd0, busy}, 64'd0);
    check("idle_ack_fv", {63'd0, frame_valid}, 64'd0);

    // Overlapping next_out at beat 10, same-address read at beat 3.
    run_frame(16'h0080, 1'b0, 10, 3, -1);
    check("ovl_ovf_held", {63'd0, overflow}, 64'd1);
`ifdef IDFT_CAPTURE_DROP_CNT_EN
    exp_dc = 16'd1;
    check("ovl_dc", {48'd0, drop_count}, {48'd0, exp_dc});
`endif
    do_read(10, "ovl_rd10");
    do_read(3, "ovl_rd3");
    frame_ack = 1'b1;
    overflow_clr = 1'b1;
    step();
    frame_ack = 1'b0;
    overflow_clr = 1'b0;
    check("ovl_ack_fv", {63'd0, frame_valid}, 64'd0);
    check("ovl_clr_ovf", {63'd0, overflow}, 64'd0);

    // Reset mid-capture at beat 12, then a normal frame.
    run_frame(16'h00C0, 1'b0, -1, -1, 12);
`ifdef IDFT_CAPTURE_DROP_CNT_EN
    exp_dc = 16'd0;
`endif
    run_frame(16'h0100, 1'b0, -1, -1, -1);
    do_read(0, "post_rst_rd0");
    do_read(20, "post_rst_rd20");

`ifdef IDFT_CAPTURE_DROP_CNT_EN
    // Saturation: 65537 back-to-back drops while FULL.
    next_out = 1'b1;
    repeat (65537) step();
    next_out = 1'b0;
    step();
    check("sat_dc", {48'd0, drop_count}, 64'h0000_0000_0000_FFFF);
    check("sat_ovf", {63'd0, overflow}, 64'd1);
    $display("saturation drop_count=%h", drop_count);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    check("sat_clr_dc", {48'd0, drop_count}, 64'd0);
    check("sat_clr_ovf", {63'd0, overflow}, 64'd0);
    next_out = 1'b1;
    overflow_clr = 1'b1;
    step();
    next_out = 1'b0;
    overflow_clr = 1'b0;
    check("clr_inc_dc", {48'd0, drop_count}, 64'd1);
    check("clr_inc_ovf", {63'd0, overflow}, 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
